seq_divider: RTL and testbench

- Sequential 32-bit integer divider; the inverse datapath to the team's radix-2 Booth multiplier.
- Uses a non-restoring, one-bit-per-cycle algorithm.
- Handles signed (two's complement) and unsigned operands and produces quotient and remainder.
- Sits beside the multiplier in the arithmetic unit, with a start/busy/done handshake so a controller can issue one operation at a time.

---
 rtl/arith_pkg.sv | 19 +
 rtl/seq_divider_div_step.sv | 35 +++
 rtl/seq_divider.sv | 143 ++++++++++++++
 tb/tb_seq_divider.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit: divider FSM states, default
// operand width and the fill value used for a divide-by-zero quotient.
package arith_pkg;

    // Default operand, quotient and remainder width.
    localparam int DIV_WIDTH = 32;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } div_state_t;

    // Every quotient bit takes this value on a divide by zero (all ones).
    localparam logic DIV_ZERO_Q_BIT = 1'b1;

endpackage : arith_pkg

// File: rtl/seq_divider_div_step.sv
// One non-restoring division step. The partial remainder and the incoming
// dividend bit are shifted together, then the divisor is subtracted when the
// old partial remainder is non-negative or added back when it is negative.
// Purely combinational, so a radix-4 variant can chain two of these.
module div_step
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   p,
    input  logic [WIDTH-1:0] d,
    input  logic             dividend_bit,
    output logic [WIDTH:0]   p_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] d_ext;

    // Shift in the next dividend bit, then add or subtract the divisor by old sign.
    always_comb begin
        // NOTE: every output of an always_comb is assigned on every path; an
        // output left unassigned on some path would infer a latch.
        shifted = {p[WIDTH-1:0], dividend_bit};
        d_ext   = {1'b0, d};
        p_next  = '0;
        if (p[WIDTH]) begin
            p_next = shifted + d_ext;
        end else begin
            p_next = shifted - d_ext;
        end
        q_bit = ~p_next[WIDTH];
    end

endmodule : div_step

// File: rtl/seq_divider.sv
// Sequential WIDTH-bit integer divider (non-restoring, one quotient bit per
// clock) for signed and unsigned operands. The operand magnitudes are divided
// and the signs are applied in a final correction cycle. A start/busy/done
// handshake lets a controller issue one operation at a time.
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   p;          // signed partial remainder
    logic [WIDTH-1:0] q;          // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] d;          // divisor magnitude
    logic             q_neg;
    logic             r_neg;
    logic             dz;

    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] quot_final;
    logic [WIDTH-1:0] rem_final;
    logic [WIDTH-1:0] zero_rem;
    logic             last_iter;

    logic [WIDTH:0]   step_p;
    logic             step_bit;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p            (p),
        .d            (d),
        .dividend_bit (q[WIDTH-1]),
        .p_next       (step_p),
        .q_bit        (step_bit)
    );

    // Operand magnitudes at accept, and remainder correction plus sign application for FIX.
    always_comb begin
        dividend_neg = signed_op & dividend[WIDTH-1];
        divisor_neg  = signed_op & divisor[WIDTH-1];
        dividend_mag = dividend_neg ? -dividend : dividend;
        divisor_mag  = divisor_neg  ? -divisor  : divisor;
        // A negative partial remainder is one divisor short; the true
        // remainder lies in [0, d) so WIDTH-bit arithmetic is exact here.
        rem_mag      = p[WIDTH] ? (p[WIDTH-1:0] + d) : p[WIDTH-1:0];
        quot_final   = q_neg ? -q : q;
        rem_final    = r_neg ? -rem_mag : rem_mag;
        // On divide by zero q still holds |dividend|; re-applying the dividend
        // sign restores the original bit pattern (MIN maps onto itself).
        zero_rem     = r_neg ? -q : q;
        last_iter    = (count == CW'(WIDTH - 1));
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            p           <= '0;
            q           <= '0;
            d           <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            // NOTE: state registers take non-blocking assignments so every
            // right-hand side sees the values from before this edge.
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        q           <= dividend_mag;
                        d           <= divisor_mag;
                        p           <= '0;
                        count       <= '0;
                        q_neg       <= dividend_neg ^ divisor_neg;
                        r_neg       <= dividend_neg;
                        dz          <= (divisor == '0);
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        state       <= (divisor == '0) ? FIX : ITER;
                    end
                end
                ITER: begin
                    p     <= step_p;
                    q     <= {q[WIDTH-2:0], step_bit};
                    count <= count + 1'b1;
                    if (last_iter) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dz) begin
                        quotient    <= {WIDTH{DIV_ZERO_Q_BIT}};
                        remainder   <= zero_rem;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= quot_final;
                        remainder   <= rem_final;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32). A behavioural model built
// from plain integer division and a latency countdown is compared against the
// DUT outputs on every falling edge; directed operations add literal checks
// of results, latency, handshake and asynchronous reset.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int checks = 0;
    int failures = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result {div_by_zero, quotient, remainder} from plain integer arithmetic.
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        longint       sa;
        longint       sb;
        logic [W-1:0] rq;
        logic [W-1:0] rr;
        if (b == '0) begin
            rq = '1;
            rr = a;
            return {1'b1, rq, rr};
        end
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            rq = W'(sa / sb);
            rr = W'(sa % sb);
        end else begin
            rq = a / b;
            rr = a % b;
        end
        return {1'b0, rq, rr};
    endfunction

    // Behavioural model: an accepted operation completes after a fixed number of edges.
    logic         m_busy;
    logic         m_done;
    logic         m_dz;
    logic [W-1:0] m_q;
    logic [W-1:0] m_r;
    logic [2*W:0] m_pend;
    int           m_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_pend <= '0;
            m_cnt  <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_dz   <= m_pend[2*W];
                m_q    <= m_pend[2*W-1:W];
                m_r    <= m_pend[W-1:0];
            end
        end else if (start) begin
            m_pend <= ref_div(dividend, divisor, signed_op);
            m_cnt  <= (divisor == '0) ? 1 : W + 1;
            m_busy <= 1'b1;
            m_dz   <= 1'b0;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        check("model handshake", {busy, done, div_by_zero}, {m_busy, m_done, m_dz});
        check("model quotient", quotient, m_q);
        check("model remainder", remainder, m_r);
    end

    // One directed operation: latency counted including the accepting edge.
    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input int elat);
        int n;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        check({name, " busy after accept"}, busy, 1'b1);
        while (!done && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({name, " done seen"}, done, 1'b1);
        check({name, " latency"}, n, elat);
        check({name, " quotient"}, quotient, eq);
        check({name, " remainder"}, remainder, er);
        check({name, " div_by_zero"}, div_by_zero, edz);
        check({name, " busy at done"}, busy, 1'b0);
        @(negedge clk);
        check({name, " done one cycle"}, done, 1'b0);
        check({name, " quotient held"}, quotient, eq);
    endtask

    initial begin
        #200us;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // Pin the model with hand-computed values.
        check("ref 100/7 u", ref_div(32'd100, 32'd7, 1'b0), {1'b0, 32'd14, 32'd2});
        check("ref -100/7 s", ref_div(32'hFFFFFF9C, 32'd7, 1'b1),
              {1'b0, 32'hFFFFFFF2, 32'hFFFFFFFE});
        check("ref MIN/-1 s", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1),
              {1'b0, 32'h80000000, 32'h0});
        check("ref x/0", ref_div(32'h12345678, 32'h0, 1'b0),
              {1'b1, 32'hFFFFFFFF, 32'h12345678});

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset busy/done/dz", {busy, done, div_by_zero}, 3'b000);
        check("reset quotient", quotient, 32'h0);
        check("reset remainder", remainder, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        do_op("u 100/7",        32'd100,       32'd7,         1'b0, 32'd14,       32'd2,        1'b0, 34);
        do_op("s -100/7",       32'hFFFFFF9C,  32'd7,         1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34);
        do_op("s 100/-7",       32'd100,       32'hFFFFFFF9,  1'b1, 32'hFFFFFFF2, 32'd2,        1'b0, 34);
        do_op("div0",           32'h12345678,  32'h0,         1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 2);
        do_op("u 1000/3 clr dz",32'd1000,      32'd3,         1'b0, 32'd333,      32'd1,        1'b0, 34);
        do_op("s div0 -7",      32'hFFFFFFF9,  32'h0,         1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 2);
        do_op("s MIN/-1",       32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000, 32'h0,        1'b0, 34);
        do_op("u max/1",        32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF, 32'h0,        1'b0, 34);
        do_op("u 5/9",          32'd5,         32'd9,         1'b0, 32'd0,        32'd5,        1'b0, 34);
        do_op("s 0/5",          32'd0,         32'd5,         1'b1, 32'd0,        32'd0,        1'b0, 34);
        do_op("u MIN/max",      32'h80000000,  32'hFFFFFFFF,  1'b0, 32'd0,        32'h80000000, 1'b0, 34);

        // Start held high: inputs scrambled while busy must not disturb the result.
        @(negedge clk);
        dividend  = 32'd1000;
        divisor   = 32'd3;
        signed_op = 1'b0;
        start     = 1'b1;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (!done) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
        end
        check("held start first done", done, 1'b1);
        check("held start first quotient", quotient, 32'd333);
        check("held start first remainder", remainder, 32'd1);
        dividend = 32'd1000;
        divisor  = 32'd3;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n >= 2 && !done) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
        end while (!done && n < 100);
        start = 1'b0;
        check("held start period", n, W + 3);
        check("held start second quotient", quotient, 32'd333);
        check("held start second remainder", remainder, 32'd1);
        repeat (3) @(negedge clk);

        // A start pulse during the DONE cycle is ignored.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done-start done seen", done, 1'b1);
        dividend = 32'd77;
        divisor  = 32'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done-start ignored busy", busy, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("done-start stays idle", {busy, done, div_by_zero}, 3'b000);
            check("done-start quotient held", quotient, 32'd14);
        end

        // Asynchronous reset during iteration 10 of 1000/3.
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async reset busy/done/dz", {busy, done, div_by_zero}, 3'b000);
        check("async reset quotient", quotient, 32'h0);
        check("async reset remainder", remainder, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            check("no done after abort", done, 1'b0);
        end
        do_op("u 1000/3 after reset", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, 34);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_divider
